// File: rtl/mux81_arb_pkg.sv
// Shared definitions for the round-robin arbiter that fronts mux81.
package mux81_arb_pkg;
  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {IDLE, GRANT} arb_state_e;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set bit of req scanning from ptr upward, wrapping.
module rr_pick
  import mux81_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] win,
  output logic             any
);
  logic [SEL_W-1:0] idx;

  // Scan offsets high to low so the smallest offset from ptr is the last writer.
  always_comb begin
    win = '0;
    idx = '0;
    any = |req;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = ptr + SEL_W'(i);
      if (req[idx]) win = idx;
    end
  end
endmodule

// File: rtl/mux81_rr_arbiter.sv
// Round-robin owner selection for a shared mux81, with a hold limit against monopolisation.
module mux81_rr_arbiter
  import mux81_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [SEL_W-1:0] S
);
  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  arb_state_e       state;
  logic [SEL_W-1:0] ptr;
  logic [3:0]       hold_cnt;
  logic [N_REQ-1:0] own_oh;
  logic [N_REQ-1:0] cand;
  logic [SEL_W-1:0] win;
  logic             any;
  logic             rel;

  // While granted the owner is masked out, so 'any' means "a contender exists";
  // ptr is already owner+1, so the search naturally gives the owner lowest priority.
  always_comb begin
    own_oh = onehot(S);
    cand   = (state == GRANT) ? (req & ~own_oh) : req;
    rel    = !(|(req & own_oh)) || ((hold_cnt == HOLD_MAX) && any);
  end

  rr_pick u_pick (
    .req (cand),
    .ptr (ptr),
    .win (win),
    .any (any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      S         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en && any) begin
            state     <= GRANT;
            gnt       <= onehot(win);
            gnt_valid <= 1'b1;
            S         <= win;
            hold_cnt  <= 4'd1;
            ptr       <= win + 1'b1;
          end else begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
          end
        end
        GRANT: begin
          if (rel) begin
            if (en && any) begin
              gnt      <= onehot(win);
              S        <= win;
              hold_cnt <= 4'd1;
              ptr      <= win + 1'b1;
            end else begin
              // S is left alone so the mux output stays stable while idle.
              state     <= IDLE;
              gnt       <= '0;
              gnt_valid <= 1'b0;
            end
          end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mux81_rr_arbiter.sv
// Directed table, rotation, async reset and randomized checks against a behavioural model.
module tb_mux81_rr_arbiter;
  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic [2:0] S;

  int checks = 0;
  int errors = 0;

  // Model: owner index (-1 = nobody), cycles held, next search start, last select.
  int m_owner, m_held, m_start, m_sel;

  typedef struct {
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic       vld;
    logic [2:0] s;
  } vec_t;
  vec_t vecs[$];

  mux81_rr_arbiter #(.MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .S         (S)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input int start);
    for (int i = 0; i < 8; i++)
      if (r[(start + i) % 8]) return (start + i) % 8;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_held = 0; m_start = 0; m_sel = 0;
  endtask

  task automatic model_step(input logic e, input logic [7:0] r);
    logic [7:0] others;
    bit rel;
    if (m_owner < 0) begin
      if (e && r != 0) begin
        m_owner = pick(r, m_start); m_held = 1;
        m_start = (m_owner + 1) % 8; m_sel = m_owner;
      end
    end else begin
      others = r & ~(8'd1 << m_owner);
      rel = !r[m_owner] || (m_held >= MH && others != 0);
      if (rel) begin
        if (e && others != 0) begin
          m_owner = pick(others, (m_owner + 1) % 8); m_held = 1;
          m_start = (m_owner + 1) % 8; m_sel = m_owner;
        end else m_owner = -1;
      end else if (m_held < MH) m_held++;
    end
  endtask

  task automatic step(input logic e, input logic [7:0] r);
    en = e; req = r;
    model_step(e, r);
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] m_gnt();
    return (m_owner < 0) ? 8'h00 : (8'd1 << m_owner);
  endfunction

  initial begin
    rst_n = 1'b0; en = 1'b0; req = 8'h00;
    model_reset();
    #12;
    chk("reset_gnt", {24'd0, gnt}, 32'h0);
    chk("reset_vld", {31'd0, gnt_valid}, 32'h0);
    chk("reset_S", {29'd0, S}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    vecs.push_back('{1'b1, 8'h04, 8'h04, 1'b1, 3'd2});
    vecs.push_back('{1'b1, 8'h00, 8'h00, 1'b0, 3'd2});
    for (int i = 0; i < 10; i++) vecs.push_back('{1'b1, 8'h01, 8'h01, 1'b1, 3'd0});
    vecs.push_back('{1'b1, 8'h81, 8'h80, 1'b1, 3'd7});
    vecs.push_back('{1'b1, 8'h00, 8'h00, 1'b0, 3'd7});
    vecs.push_back('{1'b1, 8'h40, 8'h40, 1'b1, 3'd6});
    for (int i = 0; i < 3; i++) vecs.push_back('{1'b1, 8'h41, 8'h40, 1'b1, 3'd6});
    vecs.push_back('{1'b1, 8'h41, 8'h01, 1'b1, 3'd0});
    vecs.push_back('{1'b1, 8'h00, 8'h00, 1'b0, 3'd0});
    vecs.push_back('{1'b1, 8'h08, 8'h08, 1'b1, 3'd3});
    vecs.push_back('{1'b0, 8'h0C, 8'h08, 1'b1, 3'd3});
    vecs.push_back('{1'b0, 8'h04, 8'h00, 1'b0, 3'd3});
    vecs.push_back('{1'b0, 8'h04, 8'h00, 1'b0, 3'd3});
    vecs.push_back('{1'b1, 8'h04, 8'h04, 1'b1, 3'd2});
    vecs.push_back('{1'b1, 8'h00, 8'h00, 1'b0, 3'd2});
    vecs.push_back('{1'b1, 8'h20, 8'h20, 1'b1, 3'd5});

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].req);
      chk($sformatf("vec%0d_gnt", i), {24'd0, gnt}, {24'd0, vecs[i].gnt});
      chk($sformatf("vec%0d_vld", i), {31'd0, gnt_valid}, {31'd0, vecs[i].vld});
      chk($sformatf("vec%0d_S", i), {29'd0, S}, {29'd0, vecs[i].s});
    end

    // Async reset between edges while owner 5 holds the mux.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt", {24'd0, gnt}, 32'h0);
    chk("arst_vld", {31'd0, gnt_valid}, 32'h0);
    chk("arst_S", {29'd0, S}, 32'h0);
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;

    // Full contention: each owner keeps the mux exactly MH cycles, in index order.
    for (int c = 0; c < 36; c++) begin
      step(1'b1, 8'hFF);
      chk($sformatf("rot%0d_gnt", c), {24'd0, gnt}, 32'd1 << ((c / MH) % 8));
      chk($sformatf("rot%0d_S", c), {29'd0, S}, (c / MH) % 8);
    end

    begin
      logic [7:0] r;
      logic       e;
      r = 8'h00;
      for (int c = 0; c < 400; c++) begin
        e = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 3))
            0: r = 8'h00;
            1: r = 8'd1 << $urandom_range(0, 7);
            default: r = 8'($urandom);
          endcase
        end
        step(e, r);
        chk($sformatf("rnd%0d_gnt", c), {24'd0, gnt}, {24'd0, m_gnt()});
        chk($sformatf("rnd%0d_vld", c), {31'd0, gnt_valid}, (m_owner >= 0) ? 32'd1 : 32'd0);
        chk($sformatf("rnd%0d_S", c), {29'd0, S}, m_sel);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
